// File: rtl/packet_sequencer.sv
// Packet sequencer: plays back entries of a writable packet table on a
// valid/ready stream. Supports single-pass or looping playback, abort,
// and a one-cycle done pulse when a single pass completes normally.
module packet_sequencer #(
  parameter int unsigned PKT_W = 38,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PKT_W-1:0] wr_data,
  input  logic [AW:0]      seq_len,
  input  logic             loop_en,
  input  logic             start,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] packet_out,
  output logic [AW-1:0]    pc,
  output logic             busy,
  output logic             done
);

  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Packet table; not touched by RST so contents survive a reset.
  logic [PKT_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]    pc_q, pc_d;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic             valid_q, valid_d;
  logic [LW-1:0]    len_q, len_d;
  logic             loop_q, loop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             launch_c;
  logic             xfer_c;
  logic             last_c;
  logic             load_c;
  logic [AW-1:0]    rd_addr_c;

  assign launch_c = start && (seq_len != '0);
  assign xfer_c   = valid_q && out_ready;
  assign last_c   = ({1'b0, pc_q} == (len_q - LW'(1)));

  // Table write port; a same-edge read of the written entry sees old data.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over a simultaneous final transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (launch_c) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer_c && last_c && !loop_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output/datapath next values: pc advance, wrap, and table prefetch.
  always_comb begin
    pc_d      = pc_q;
    pkt_d     = pkt_q;
    valid_d   = valid_q;
    len_d     = len_q;
    loop_d    = loop_q;
    load_c    = 1'b0;
    rd_addr_c = '0;
    busy_d    = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (launch_c) begin
          len_d     = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
          loop_d    = loop_en;
          pc_d      = '0;
          valid_d   = 1'b1;
          load_c    = 1'b1;
          rd_addr_c = '0;
        end
      end
      S_RUN: begin
        if (abort) begin
          valid_d = 1'b0;
        end else if (xfer_c) begin
          if (!last_c) begin
            pc_d      = pc_q + AW'(1);
            load_c    = 1'b1;
            rd_addr_c = pc_q + AW'(1);
          end else if (loop_q) begin
            pc_d      = '0;
            load_c    = 1'b1;
            rd_addr_c = '0;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        valid_d = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase
    if (load_c) begin
      pkt_d = mem_q[rd_addr_c];
    end
  end

  // Registered outputs and latched sequence parameters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q    <= '0;
      pkt_q   <= '0;
      valid_q <= 1'b0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid  = valid_q;
  assign packet_out = pkt_q;
  assign pc         = pc_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_packet_sequencer.sv
// Scoreboard bench for packet_sequencer: the driver pushes the packets a
// sequence must deliver (derived from a table model), and an independent
// monitor pops and compares one entry per accepted transfer.
module tb_packet_sequencer;

  localparam int unsigned PKT_W  = 38;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned LW     = AW + 1;
  localparam int          BUDGET = 2000;

  typedef struct packed {
    logic [AW-1:0]    idx;
    logic [PKT_W-1:0] data;
  } exp_t;

  logic             CLK;
  logic             RST;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [PKT_W-1:0] wr_data;
  logic [AW:0]      seq_len;
  logic             loop_en;
  logic             start;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [PKT_W-1:0] packet_out;
  logic [AW-1:0]    pc;
  logic             busy;
  logic             done;

  packet_sequencer #(.PKT_W(PKT_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seq_len(seq_len), .loop_en(loop_en), .start(start), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .packet_out(packet_out),
    .pc(pc), .busy(busy), .done(done)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [PKT_W-1:0] model [DEPTH];
  exp_t             exp_q [$];

  logic             stall_v;
  logic [PKT_W-1:0] stall_pkt;
  logic [AW-1:0]    stall_pc;

  logic [PKT_W-1:0] pA, pB, pC, pD, pX, pY;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic void push_val(input int idx, input logic [PKT_W-1:0] d);
    exp_t e;
    e.idx  = AW'(idx);
    e.data = d;
    exp_q.push_back(e);
  endfunction

  // Monitor: every accepted transfer must match the head of the scoreboard,
  // and a stalled packet must not change.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      stall_v = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (stall_v && out_valid) begin
        chk("hold_pkt", 64'(packet_out), 64'(stall_pkt));
        chk("hold_pc", 64'(pc), 64'(stall_pc));
      end
      stall_v   = out_valid && !out_ready && !abort;
      stall_pkt = packet_out;
      stall_pc  = pc;
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer actual=pc%0d/%h required=none", pc, packet_out);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_pc", 64'(pc), 64'(e.idx));
          chk("xfer_pkt", 64'(packet_out), 64'(e.data));
        end
      end
    end
  end

  task automatic tbl_write(input int a, input logic [PKT_W-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    model[a] = d;
  endtask

  // Hold out_ready per mode until the scoreboard drains: 0=always,
  // 1=pattern 1,0,0,1, 2=random.
  task automatic drain(input int rmode);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < BUDGET) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom % 2);
      endcase
      tick();
      cyc++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic end_loop(input int d0);
    abort     = 1'b1;
    out_ready = 1'($urandom % 2);
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    tick();
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_done_cnt", 64'(done_cnt), 64'(d0));
    chk("abort_q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_seq(input int len, input bit lp, input int nx, input int rmode);
    int L;
    int cnt;
    int d0;
    d0 = done_cnt;
    L  = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    seq_len = LW'(len);
    loop_en = lp;
    out_ready = 1'b0;
    if (len == 0) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("len0_valid", 64'(out_valid), 64'd0);
      chk("len0_busy", 64'(busy), 64'd0);
      tick();
      chk("len0_done", 64'(done), 64'd0);
      chk("len0_done_cnt", 64'(done_cnt), 64'(d0));
    end else begin
      cnt = lp ? nx : L;
      for (int n = 0; n < cnt; n++) push_val(n % L, model[n % L]);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_valid", 64'(out_valid), 64'd1);
      chk("start_pc", 64'(pc), 64'd0);
      chk("start_busy", 64'(busy), 64'd1);
      drain(rmode);
      if (!lp) begin
        out_ready = 1'b0;
        chk("end_done", 64'(done), 64'd1);
        chk("end_valid", 64'(out_valid), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
        tick();
        chk("end_done_low", 64'(done), 64'd0);
        chk("end_done_cnt", 64'(done_cnt), 64'(d0 + 1));
      end else begin
        chk("loop_no_done", 64'(done_cnt), 64'(d0));
        end_loop(d0);
      end
    end
  endtask

  initial begin
    int d0;
    pA = PKT_W'(38'h0A_AAAA_0001);
    pB = PKT_W'(38'h0B_BBBB_0002);
    pC = PKT_W'(38'h0C_CCCC_0003);
    pD = PKT_W'(38'h0D_DDDD_0004);
    pX = PKT_W'(38'h31_2345_6789);
    pY = PKT_W'(38'h2F_0F0F_F0F0);
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    seq_len = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    stall_v = 1'b0; stall_pkt = '0; stall_pc = '0;

    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_pkt", 64'(packet_out), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    tbl_write(0, pA); tbl_write(1, pB); tbl_write(2, pC); tbl_write(3, pD);
    run_seq(4, 1'b0, 0, 0);
    run_seq(4, 1'b0, 0, 1);
    run_seq(3, 1'b1, 8, 0);
    run_seq(0, 1'b0, 0, 0);

    for (int i = 0; i < int'(DEPTH); i++) tbl_write(i, PKT_W'({$urandom, $urandom}));
    run_seq(int'(DEPTH) + 1, 1'b0, 0, 2);

    // Write to the entry on packet_out during a stall, then see it after wrap.
    tbl_write(0, pA); tbl_write(1, pB); tbl_write(2, pC); tbl_write(3, pD);
    d0 = done_cnt;
    push_val(0, pA); push_val(1, pB); push_val(2, pC);
    push_val(0, pA); push_val(1, pX); push_val(2, pC);
    seq_len = LW'(3); loop_en = 1'b1; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; wr_en = 1'b1; wr_addr = AW'(1); wr_data = pX;
    tick();
    wr_en = 1'b0; model[1] = pX;
    chk("stall_wr_pkt", 64'(packet_out), 64'(pB));
    chk("stall_wr_pc", 64'(pc), 64'd1);
    drain(0);
    end_loop(d0);

    // Write on the same edge that prefetches that entry: old data delivered.
    d0 = done_cnt;
    push_val(0, pA); push_val(1, pX); push_val(2, pC); push_val(0, pA); push_val(1, pY);
    seq_len = LW'(3); loop_en = 1'b1; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b1; wr_en = 1'b1; wr_addr = AW'(1); wr_data = pY;
    tick();
    wr_en = 1'b0; model[1] = pY;
    drain(0);
    end_loop(d0);

    // Asynchronous reset at pc=2; table survives and next start restarts at 0.
    tbl_write(1, pB);
    push_val(0, pA); push_val(1, pB);
    seq_len = LW'(4); loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk("pre_rst_pc", 64'(pc), 64'd2);
    out_ready = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_pc", 64'(pc), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_pkt", 64'(packet_out), 64'd0);
    @(negedge CLK);
    #1;
    RST = 1'b0;
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_q", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    run_seq(4, 1'b0, 0, 0);

    for (int k = 0; k < 12; k++) begin
      for (int w = 0; w < 3; w++) tbl_write($urandom_range(0, DEPTH - 1), PKT_W'({$urandom, $urandom}));
      run_seq($urandom_range(0, 63), 1'($urandom % 2), $urandom_range(1, 3 * DEPTH), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_sequencer.md
PACKET_SEQUENCER -- requirements
Module: packet_sequencer

Interface
REQ-001 SHALL have parameter PKT_W, default 38, packet width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of packet table entries (power of two, >=2).
REQ-003 SHALL have parameter AW, default 5, table address width, equal to log2(DEPTH).
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 wr_en  input  1  table write strobe.
REQ-007 wr_addr  input  AW  table write address.
REQ-008 wr_data  input  PKT_W  table write data.
REQ-009 seq_len  input  AW+1  number of entries to send, sampled at start.
REQ-010 loop_en  input  1  wrap to entry 0 after last entry, sampled at start.
REQ-011 start  input  1  begin sequence (level-sampled in IDLE).
REQ-012 abort  input  1  terminate sequence.
REQ-013 out_valid  output  1  packet_out holds a valid packet.
REQ-014 out_ready  input  1  consumer accepts packet.
REQ-015 packet_out  output  PKT_W  current packet.
REQ-016 pc  output  AW  index of the entry on packet_out.
REQ-017 busy  output  1  high in RUN.
REQ-018 done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-019 SHALL hold a DEPTH x PKT_W table; all entries zero at power-up; contents unaffected by RST.
REQ-020 SHALL write wr_data to table[wr_addr] on a clock edge with wr_en=1, in any state.
REQ-021 SHALL implement states IDLE, RUN, DONE.
REQ-022 IDLE: start=1 and seq_len!=0 -> RUN; start with seq_len=0 ignored (remain IDLE, no done).
REQ-023 Effective length L = min(seq_len, DEPTH), latched with loop_en on the start edge.
REQ-024 On entering RUN: pc=0, packet_out=table[0] registered, out_valid=1 in the first RUN cycle (latency 1 clock from start sampled).
REQ-025 Transfer occurs on a clock edge with out_valid=1 and out_ready=1.
REQ-026 On transfer with pc<L-1: pc<=pc+1, packet_out<=table[pc+1], out_valid stays 1 (throughput one packet/clock).
REQ-027 On transfer with pc=L-1 and loop_en latched=1: pc<=0, packet_out<=table[0], remain RUN.
REQ-028 On transfer with pc=L-1 and loop_en latched=0: -> DONE, out_valid<=0.
REQ-029 DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-030 out_valid=1 and out_ready=0: packet_out and pc SHALL hold stable.
REQ-031 A table write to the address currently on packet_out SHALL NOT change packet_out; write with same-edge read of that address SHALL return the old data.
REQ-032 abort=1 in RUN: -> IDLE next edge, out_valid<=0, no done pulse; abort has priority over a simultaneous transfer.
REQ-033 abort in IDLE or DONE SHALL have no effect; DONE still returns to IDLE.
REQ-034 start in RUN or DONE SHALL be ignored.
REQ-035 busy=1 exactly when state=RUN; pc SHALL retain last value in IDLE/DONE.

Reset
REQ-036 RST=1 SHALL immediately force state=IDLE, pc=0, out_valid=0, busy=0, done=0, packet_out=0, latched length/loop cleared.
REQ-037 RST asserted mid-sequence SHALL discard the sequence; after release a new start is required.

Verification
REQ-038 Load table[0..3]=A,B,C,D; seq_len=4, loop_en=0, out_ready=1, start pulse -> out_valid one clock later, packets A,B,C,D on consecutive clocks, pc 0..3, done pulse once, busy low after.
REQ-039 Same, out_ready toggled 1,0,0,1,... -> each packet held while ready=0, order A,B,C,D, no duplicates or drops.
REQ-040 seq_len=3, loop_en=1, ready=1 for 8 transfers -> A,B,C,A,B,C,A,B; no done; abort -> out_valid=0 next clock, no done.
REQ-041 seq_len=0 start -> stays IDLE, out_valid=0, done=0; seq_len=DEPTH+1 (AW+1 bits max) -> exactly DEPTH packets sent.
REQ-042 During RUN with pc=1, write table[1]=X while ready=0 -> packet_out stays B; after wrap (loop) entry 1 yields X.
REQ-043 RST asserted at pc=2 mid-RUN -> outputs reset asynchronously; table contents preserved, next start resends from entry 0.
